tl_a_channel_arbiter: RTL and testbench

- Shares one 64-bit TileLink-UL A channel (the coupler's master-side A input) between two requesters, with round-robin arbitration and per-message locking so multi-beat bursts are never interleaved.
- Widens the 3-bit requester source ID to 4 bits by prefixing the requester index.
- Routes D-channel responses back to the requester selected by source bit 3.
- Sits directly upstream of the interconnect coupler on the master side.

---
 rtl/tl_a_channel_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_tl_a_channel_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_channel_arbiter.sv
// Two-requester round-robin arbiter for a 64-bit TileLink-UL A channel.
// Bursts are locked to one requester; D responses are routed by source bit 3.
module tl_a_channel_arbiter #(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in0_a_valid,
  output logic        in0_a_ready,
  input  logic [2:0]  in0_a_opcode,
  input  logic [2:0]  in0_a_param,
  input  logic [3:0]  in0_a_size,
  input  logic [2:0]  in0_a_source,
  input  logic [31:0] in0_a_address,
  input  logic [7:0]  in0_a_mask,
  input  logic [63:0] in0_a_data,
  input  logic        in0_a_corrupt,
  input  logic        in1_a_valid,
  output logic        in1_a_ready,
  input  logic [2:0]  in1_a_opcode,
  input  logic [2:0]  in1_a_param,
  input  logic [3:0]  in1_a_size,
  input  logic [2:0]  in1_a_source,
  input  logic [31:0] in1_a_address,
  input  logic [7:0]  in1_a_mask,
  input  logic [63:0] in1_a_data,
  input  logic        in1_a_corrupt,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [2:0]  out_a_param,
  output logic [3:0]  out_a_size,
  output logic [3:0]  out_a_source,
  output logic [31:0] out_a_address,
  output logic [7:0]  out_a_mask,
  output logic [63:0] out_a_data,
  output logic        out_a_corrupt,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [1:0]  out_d_param,
  input  logic [3:0]  out_d_size,
  input  logic [3:0]  out_d_source,
  input  logic [2:0]  out_d_sink,
  input  logic        out_d_denied,
  input  logic [63:0] out_d_data,
  input  logic        out_d_corrupt,
  output logic        in0_d_valid,
  input  logic        in0_d_ready,
  output logic [2:0]  in0_d_opcode,
  output logic [1:0]  in0_d_param,
  output logic [3:0]  in0_d_size,
  output logic [2:0]  in0_d_source,
  output logic [2:0]  in0_d_sink,
  output logic        in0_d_denied,
  output logic [63:0] in0_d_data,
  output logic        in0_d_corrupt,
  output logic        in1_d_valid,
  input  logic        in1_d_ready,
  output logic [2:0]  in1_d_opcode,
  output logic [1:0]  in1_d_param,
  output logic [3:0]  in1_d_size,
  output logic [2:0]  in1_d_source,
  output logic [2:0]  in1_d_sink,
  output logic        in1_d_denied,
  output logic [63:0] in1_d_data,
  output logic        in1_d_corrupt
);

  localparam int LG_BEAT   = $clog2(BEAT_BYTES);
  localparam int MAX_BEATS = (1 << MAX_SIZE) / BEAT_BYTES;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [2:0] beats_left_q, beats_left_d;

  logic       sel;
  logic       fire;
  logic [3:0] beats;

  function automatic logic [3:0] beat_count(
    input logic [2:0] op,
    input logic [3:0] size
  );
    logic [3:0] n;
    if (op[2])
      n = 4'd1;
    else if (size > 4'(MAX_SIZE))
      n = 4'(MAX_BEATS);
    else if (size <= 4'(LG_BEAT))
      n = 4'd1;
    else
      n = 4'(1 << (size - 4'(LG_BEAT)));
    return n;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      beats_left_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
    end
  end

  // beats_left holds (beats still owed - 1) while LOCKED, so 8 fits in 3 bits
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beats_left_d = beats_left_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (beats == 4'd1) begin
            rr_ptr_d = ~sel;
          end else begin
            state_d      = LOCKED;
            grant_d      = sel;
            beats_left_d = 3'(beats - 4'd2);
          end
        end else if (out_a_valid) begin
          state_d      = LOCKED;
          grant_d      = sel;
          beats_left_d = 3'(beats - 4'd1);
        end
      end
      LOCKED: begin
        if (fire) begin
          if (beats_left_q == 3'd0) begin
            state_d  = IDLE;
            rr_ptr_d = ~grant_q;
          end else begin
            beats_left_d = beats_left_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == LOCKED)
      sel = grant_q;
    else if (rr_ptr_q ? in1_a_valid : in0_a_valid)
      sel = rr_ptr_q;
    else if (rr_ptr_q ? in0_a_valid : in1_a_valid)
      sel = ~rr_ptr_q;
    else
      sel = rr_ptr_q;

    out_a_valid   = sel ? in1_a_valid   : in0_a_valid;
    out_a_opcode  = sel ? in1_a_opcode  : in0_a_opcode;
    out_a_param   = sel ? in1_a_param   : in0_a_param;
    out_a_size    = sel ? in1_a_size    : in0_a_size;
    out_a_address = sel ? in1_a_address : in0_a_address;
    out_a_mask    = sel ? in1_a_mask    : in0_a_mask;
    out_a_data    = sel ? in1_a_data    : in0_a_data;
    out_a_corrupt = sel ? in1_a_corrupt : in0_a_corrupt;
    out_a_source  = {sel, sel ? in1_a_source : in0_a_source};

    fire        = out_a_valid & out_a_ready;
    beats       = beat_count(out_a_opcode, out_a_size);
    in0_a_ready = fire & ~sel;
    in1_a_ready = fire & sel;

    in0_d_valid   = out_d_valid & ~out_d_source[3];
    in1_d_valid   = out_d_valid & out_d_source[3];
    out_d_ready   = out_d_source[3] ? in1_d_ready : in0_d_ready;
    in0_d_opcode  = out_d_opcode;
    in0_d_param   = out_d_param;
    in0_d_size    = out_d_size;
    in0_d_source  = out_d_source[2:0];
    in0_d_sink    = out_d_sink;
    in0_d_denied  = out_d_denied;
    in0_d_data    = out_d_data;
    in0_d_corrupt = out_d_corrupt;
    in1_d_opcode  = out_d_opcode;
    in1_d_param   = out_d_param;
    in1_d_size    = out_d_size;
    in1_d_source  = out_d_source[2:0];
    in1_d_sink    = out_d_sink;
    in1_d_denied  = out_d_denied;
    in1_d_data    = out_d_data;
    in1_d_corrupt = out_d_corrupt;
  end

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Bench for tl_a_channel_arbiter: vector table, directed burst/stall
// sequences and randomized traffic against a message-level model.
module tb_tl_a_channel_arbiter;

  typedef struct packed {
    logic        valid;
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [2:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } req_t;

  typedef struct {
    bit         v0, v1;
    logic [2:0] op0;
    logic [3:0] sz0;
    logic [2:0] s0;
    logic [2:0] op1;
    logic [3:0] sz1;
    logic [2:0] s1;
    bit         rdy;
    bit         ev, er0, er1;
    logic [3:0] esrc;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  req_t rq0, rq1;
  logic in0_a_ready, in1_a_ready;
  logic out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param;
  logic [3:0]  out_a_size, out_a_source;
  logic [31:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode, out_d_sink;
  logic [1:0]  out_d_param;
  logic [3:0]  out_d_size, out_d_source;
  logic        out_d_denied, out_d_corrupt;
  logic [63:0] out_d_data;
  logic        in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0]  in0_d_opcode, in0_d_source, in0_d_sink;
  logic [2:0]  in1_d_opcode, in1_d_source, in1_d_sink;
  logic [1:0]  in0_d_param, in1_d_param;
  logic [3:0]  in0_d_size, in1_d_size;
  logic        in0_d_denied, in0_d_corrupt, in1_d_denied, in1_d_corrupt;
  logic [63:0] in0_d_data, in1_d_data;

  tl_a_channel_arbiter dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(rq0.valid), .in0_a_ready(in0_a_ready),
    .in0_a_opcode(rq0.opcode), .in0_a_param(rq0.param),
    .in0_a_size(rq0.size), .in0_a_source(rq0.source),
    .in0_a_address(rq0.address), .in0_a_mask(rq0.mask),
    .in0_a_data(rq0.data), .in0_a_corrupt(rq0.corrupt),
    .in1_a_valid(rq1.valid), .in1_a_ready(in1_a_ready),
    .in1_a_opcode(rq1.opcode), .in1_a_param(rq1.param),
    .in1_a_size(rq1.size), .in1_a_source(rq1.source),
    .in1_a_address(rq1.address), .in1_a_mask(rq1.mask),
    .in1_a_data(rq1.data), .in1_a_corrupt(rq1.corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
    .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask),
    .out_a_data(out_a_data), .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
    .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data), .out_d_corrupt(out_d_corrupt),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
    .in0_d_opcode(in0_d_opcode), .in0_d_param(in0_d_param),
    .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
    .in0_d_sink(in0_d_sink), .in0_d_denied(in0_d_denied),
    .in0_d_data(in0_d_data), .in0_d_corrupt(in0_d_corrupt),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
    .in1_d_opcode(in1_d_opcode), .in1_d_param(in1_d_param),
    .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
    .in1_d_sink(in1_d_sink), .in1_d_denied(in1_d_denied),
    .in1_d_data(in1_d_data), .in1_d_corrupt(in1_d_corrupt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Message-level model: owner of the channel (-1 none), beats owed, preference
  int m_owner, m_rem, m_pref;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int beats_of(input req_t r);
    if (r.opcode >= 3'd4) return 1;
    if (r.size > 4'd6) return 8;
    if (r.size <= 4'd3) return 1;
    return (1 << r.size) / 8;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rem   = 0;
    m_pref  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic model_check(output bit f0, output bit f1);
    req_t r[2];
    int   pick;
    bit   ev, fire;
    r[0] = rq0;
    r[1] = rq1;
    if (m_owner >= 0) pick = m_owner;
    else if (r[m_pref].valid) pick = m_pref;
    else if (r[1-m_pref].valid) pick = 1 - m_pref;
    else pick = -1;
    ev   = (pick >= 0) && r[pick].valid;
    fire = ev && out_a_ready;
    f0   = fire && pick == 0;
    f1   = fire && pick == 1;
    chk("out_a_valid", out_a_valid, ev);
    chk("in0_a_ready", in0_a_ready, f0);
    chk("in1_a_ready", in1_a_ready, f1);
    if (ev) begin
      chk("out_a_source", out_a_source, {1'(pick), r[pick].source});
      chk("out_a_data", out_a_data, r[pick].data);
      chk("out_a_address", out_a_address, r[pick].address);
      chk("out_a_size", out_a_size, r[pick].size);
      chk("out_a_opcode", out_a_opcode, r[pick].opcode);
    end
    chk("in0_d_valid", in0_d_valid, out_d_valid && out_d_source < 4'd8);
    chk("in1_d_valid", in1_d_valid, out_d_valid && out_d_source >= 4'd8);
    chk("out_d_ready", out_d_ready,
        out_d_source >= 4'd8 ? in1_d_ready : in0_d_ready);
    chk("in1_d_source", in1_d_source, out_d_source % 8);
    chk("in0_d_data", in0_d_data, out_d_data);
    if (m_owner < 0 && pick >= 0) begin
      m_owner = pick;
      m_rem   = beats_of(r[pick]);
    end
    if (fire) m_rem--;
    if (m_owner >= 0 && m_rem == 0) begin
      m_pref  = 1 - m_owner;
      m_owner = -1;
    end
  endtask

  function automatic req_t rand_req(input bit v);
    req_t r;
    r.valid   = v;
    r.opcode  = 3'($urandom_range(0, 7));
    r.param   = 3'($urandom_range(0, 7));
    r.size    = 4'($urandom_range(0, 15));
    r.source  = 3'($urandom_range(0, 7));
    r.address = $urandom;
    r.mask    = 8'($urandom);
    r.data    = {$urandom, $urandom};
    r.corrupt = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    bit f0, f1;
    int n1, seen0, cyc;

    rq0 = '0;
    rq1 = '0;
    rq0.address = 32'h1000;
    rq1.address = 32'h2000;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    out_d_opcode = 3'd0; out_d_param = 2'd0; out_d_size = 4'd0;
    out_d_source = 4'd0; out_d_sink = 3'd0; out_d_denied = 1'b0;
    out_d_data = 64'd0; out_d_corrupt = 1'b0;
    in0_d_ready = 1'b0;
    in1_d_ready = 1'b0;

    tbl[0]  = '{0,0,4,0,0,4,0,0,1, 0,0,0,4'h0};
    tbl[1]  = '{1,0,4,6,5,4,0,0,1, 1,1,0,4'h5};
    tbl[2]  = '{1,1,4,0,1,4,0,2,1, 1,0,1,4'hA};
    tbl[3]  = '{1,1,4,0,1,4,0,2,1, 1,1,0,4'h1};
    tbl[4]  = '{1,1,4,0,1,4,0,2,1, 1,0,1,4'hA};
    tbl[5]  = '{1,1,4,0,1,4,0,2,1, 1,1,0,4'h1};
    tbl[6]  = '{1,0,4,0,3,4,0,2,0, 1,0,0,4'h3};
    tbl[7]  = '{1,1,4,0,3,4,0,2,0, 1,0,0,4'h3};
    tbl[8]  = '{1,1,4,0,3,4,0,2,1, 1,1,0,4'h3};
    tbl[9]  = '{1,1,4,0,1,4,0,2,1, 1,0,1,4'hA};
    tbl[10] = '{0,1,4,0,1,0,4,7,1, 1,0,1,4'hF};
    tbl[11] = '{1,1,4,0,1,0,4,7,1, 1,0,1,4'hF};
    tbl[12] = '{1,0,4,0,1,0,4,7,1, 1,1,0,4'h1};

    do_reset();
    #1;
    chk("reset_out_a_valid", out_a_valid, 0);
    chk("reset_in0_a_ready", in0_a_ready, 0);
    chk("reset_in1_a_ready", in1_a_ready, 0);
    chk("reset_d_valid", {in0_d_valid, in1_d_valid}, 0);

    foreach (tbl[i]) begin
      rq0.valid = tbl[i].v0; rq0.opcode = tbl[i].op0;
      rq0.size = tbl[i].sz0; rq0.source = tbl[i].s0;
      rq1.valid = tbl[i].v1; rq1.opcode = tbl[i].op1;
      rq1.size = tbl[i].sz1; rq1.source = tbl[i].s1;
      out_a_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_valid", i), out_a_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_r0", i), in0_a_ready, tbl[i].er0);
      chk($sformatf("tbl%0d_r1", i), in1_a_ready, tbl[i].er1);
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_src", i), out_a_source, tbl[i].esrc);
      @(posedge clock);
      #1;
    end

    // D routing
    rq0.valid = 0; rq1.valid = 0;
    out_d_valid = 1; out_d_source = 4'hA; out_d_data = 64'h1234;
    in0_d_ready = 1; in1_d_ready = 0;
    #1;
    chk("d_in1_valid", in1_d_valid, 1);
    chk("d_in1_source", in1_d_source, 3'h2);
    chk("d_in0_valid", in0_d_valid, 0);
    chk("d_ready_blocked", out_d_ready, 0);
    chk("d_in1_data", in1_d_data, 64'h1234);
    out_d_source = 4'h3;
    #1;
    chk("d_in0_valid2", in0_d_valid, 1);
    chk("d_in1_valid2", in1_d_valid, 0);
    chk("d_ready_in0", out_d_ready, 1);
    out_d_valid = 0;
    in0_d_ready = 0;

    // 8-beat PutFull from in1; in0 joins from beat 2
    do_reset();
    rq1 = '{1'b1, 3'd0, 3'd0, 4'd6, 3'd3, 32'h40, 8'hFF, 64'd0, 1'b0};
    rq0 = '{1'b0, 3'd4, 3'd0, 4'd3, 3'd6, 32'h80, 8'hFF, 64'd7, 1'b0};
    out_a_ready = 1;
    n1 = 0; seen0 = 0; cyc = 0;
    while (!seen0 && cyc < 30) begin
      if (cyc == 1) rq0.valid = 1;
      #1;
      if (in0_a_ready && n1 < 8) begin
        n_bad++;
        $display("FAIL burst_in0_ready: got 1 expected 0 at beat %0d", n1);
      end
      if (in1_a_ready) n1++;
      if (in0_a_ready) seen0 = 1;
      model_check(f0, f1);
      @(posedge clock);
      #1;
      rq1.data = rq1.data + 1;
      if (n1 == 8) rq1.valid = 0;
      if (seen0) rq0.valid = 0;
      cyc++;
    end
    chk("burst_in1_beats", n1, 8);
    chk("burst_in0_fired", seen0, 1);

    // in0 stalled 3 cycles while in1 arrives
    do_reset();
    rq0 = '{1'b1, 3'd4, 3'd0, 4'd2, 3'd4, 32'h100, 8'h0F, 64'hD0, 1'b0};
    rq1 = '{1'b0, 3'd4, 3'd0, 4'd2, 3'd1, 32'h200, 8'hF0, 64'hD1, 1'b0};
    out_a_ready = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) rq1.valid = 1;
      if (c == 3) out_a_ready = 1;
      #1;
      if (c < 4) begin
        chk($sformatf("stall%0d_src", c), out_a_source, 4'h4);
        chk($sformatf("stall%0d_data", c), out_a_data, 64'hD0);
      end else begin
        chk("stall_in1_src", out_a_source, 4'h9);
        chk("stall_in1_ready", in1_a_ready, 1);
      end
      model_check(f0, f1);
      @(posedge clock);
      #1;
      if (f0) rq0.valid = 0;
      if (f1) rq1.valid = 0;
    end

    // randomized traffic
    do_reset();
    rq0 = rand_req(0);
    rq1 = rand_req(0);
    for (int c = 0; c < 800; c++) begin
      if (!rq0.valid && $urandom_range(0, 2) == 0) rq0 = rand_req(1);
      if (!rq1.valid && $urandom_range(0, 2) == 0) rq1 = rand_req(1);
      out_a_ready  = ($urandom_range(0, 3) != 0);
      out_d_valid  = 1'($urandom_range(0, 1));
      out_d_source = 4'($urandom_range(0, 15));
      out_d_data   = {$urandom, $urandom};
      in0_d_ready  = 1'($urandom_range(0, 1));
      in1_d_ready  = 1'($urandom_range(0, 1));
      #1;
      model_check(f0, f1);
      @(posedge clock);
      #1;
      if (f0) begin
        rq0.data  = {$urandom, $urandom};
        rq0.valid = 1'($urandom_range(0, 1));
      end
      if (f1) begin
        rq1.data  = {$urandom, $urandom};
        rq1.valid = 1'($urandom_range(0, 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
